// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: decodes opcode/funct and drives per-state datapath controls.
// Optional MCYCLE_PERF_EN adds instr_count/cycle_count performance counters.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_ORI   = 6'd13,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_JAL   = 6'd3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic        ZeroExt,
    output logic [1:0]  PCSource,
    output logic        illegal,
`ifdef MCYCLE_PERF_EN
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count,
`endif
    output logic [3:0]  state
);

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_JR  = 6'd8;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRwb     = 4'd7,
        StBranch  = 4'd8,
        StIexec   = 4'd9,
        StIwb     = 4'd10,
        StJump    = 4'd11,
        StJal     = 4'd12,
        StJr      = 4'd13,
        StIllegal = 4'd14,
        StSpare   = 4'd15
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;
    logic   zext_q;

    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

    // zero is consumed by the datapath's conditional PC-write gating, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            zext_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StIllegal) begin
                illegal_q <= 1'b1;
            end
            if (state_q == StIexec) begin
                zext_q <= (opcode == OP_ORI);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        RegDst        = 2'd0;
        MemtoReg      = 2'd0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        ALUOp         = 3'd0;
        ZeroExt       = 1'b0;
        PCSource      = 2'd0;
        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'd1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = 2'd3;
                case (opcode)
                    OP_LW, OP_SW:    state_d = StMemAdr;
                    OP_RTYPE:        state_d = (funct == FN_JR) ? StJr : StExec;
                    OP_BEQ:          state_d = StBranch;
                    OP_ADDI, OP_ORI: state_d = StIexec;
                    OP_J:            state_d = StJump;
                    OP_JAL:          state_d = StJal;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                MemtoReg  = 2'd1;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemWr: begin
                IorD      = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = (funct == FN_SLL) ? 3'd4 : 3'd2;
                state_d = StRwb;
            end
            StRwb: begin
                RegDst    = 2'd1;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 3'd1;
                pc_write_cond = 1'b1;
                PCSource      = 2'd1;
                state_d       = StFetch;
            end
            StIexec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = (opcode == OP_ORI) ? 3'd3 : 3'd0;
                ZeroExt = (opcode == OP_ORI);
                state_d = StIwb;
            end
            StIwb: begin
                reg_write = 1'b1;
                ZeroExt   = zext_q;
                state_d   = StFetch;
            end
            StJump: begin
                PCSource = 2'd2;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StJal: begin
                RegDst    = 2'd2;
                MemtoReg  = 2'd2;
                reg_write = 1'b1;
                PCSource  = 2'd2;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StJr: begin
                PCSource = 2'd3;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StIllegal: state_d = StIllegal;
            default:   state_d = StFetch;
        endcase
    end

    // Enables are gated with reset_n so nothing pulses while reset is low.
    assign PCWrite     = pc_write & reset_n;
    assign PCWriteCond = pc_write_cond & reset_n;
    assign MemRead     = mem_read & reset_n;
    assign MemWrite    = mem_write & reset_n;
    assign IRWrite     = ir_write & reset_n;
    assign RegWrite    = reg_write & reset_n;
    assign illegal     = illegal_q;
    assign state       = state_q;

`ifdef MCYCLE_PERF_EN
    logic [31:0] instr_count_q, cycle_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_count_q <= 32'd0;
            cycle_count_q <= 32'd0;
        end else begin
            if (state_q != StFetch && state_q != StSpare && state_d == StFetch) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
            if (state_q != StIllegal) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
        end
    end

    assign instr_count = instr_count_q;
    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle states and controls.
module tb_multicycle_ctrl;

    logic        clock, reset_n;
    logic [5:0]  opcode, funct;
    logic        mem_ready, zero;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]  RegDst, MemtoReg;
    logic        RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic        ZeroExt;
    logic [1:0]  PCSource;
    logic        illegal;
    logic [3:0]  state;
`ifdef MCYCLE_PERF_EN
    logic [31:0] instr_count, cycle_count;
`endif

    multicycle_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ZeroExt     (ZeroExt),
        .PCSource    (PCSource),
        .illegal     (illegal),
`ifdef MCYCLE_PERF_EN
        .instr_count (instr_count),
        .cycle_count (cycle_count),
`endif
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw;
        logic [1:0] regdst, m2r;
        logic       rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       zext;
        logic [1:0] pcsrc;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       last;
        ctrl_t      c;
    } step_t;

    step_t steps[$];
    int unsigned n_vec, n_miss;
    logic [3:0]  exp_state;
    logic        exp_last;
    logic [31:0] ins_exp, cyc_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected performance counters, following the model's own state, not the DUT's.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ins_exp <= 0;
            cyc_exp <= 0;
        end else begin
            if (exp_state != 4'd14) cyc_exp <= cyc_exp + 1;
            if (exp_last) ins_exp <= ins_exp + 1;
        end
    end

    task automatic push(input logic [3:0] st, input logic rdy, input ctrl_t c);
        step_t s;
        s.st = st; s.rdy = rdy; s.last = 1'b0; s.c = c;
        steps.push_back(s);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
        ctrl_t c;
        steps.delete();
        for (int i = 0; i < fs; i++) begin
            c = '0; c.mr = 1; c.srcb = 2'd1; push(4'd0, 1'b0, c);
        end
        c = '0; c.mr = 1; c.srcb = 2'd1; c.irw = 1; c.pcw = 1; push(4'd0, 1'b1, c);
        c = '0; c.srcb = 2'd3; push(4'd1, 1'($urandom), c);
        case (op)
            6'd35, 6'd43: begin
                c = '0; c.srca = 1; c.srcb = 2'd2; push(4'd2, 1'($urandom), c);
                if (op == 6'd35) begin
                    c = '0; c.mr = 1; c.iord = 1;
                    for (int i = 0; i < ms; i++) push(4'd3, 1'b0, c);
                    push(4'd3, 1'b1, c);
                    c = '0; c.m2r = 2'd1; c.rw = 1; push(4'd4, 1'($urandom), c);
                end else begin
                    c = '0; c.iord = 1;
                    for (int i = 0; i < ms; i++) push(4'd5, 1'b0, c);
                    c.mw = 1; push(4'd5, 1'b1, c);
                end
            end
            6'd0: begin
                if (fn == 6'd8) begin
                    c = '0; c.pcsrc = 2'd3; c.pcw = 1; push(4'd13, 1'($urandom), c);
                end else begin
                    c = '0; c.srca = 1; c.aluop = (fn == 6'd0) ? 3'd4 : 3'd2;
                    push(4'd6, 1'($urandom), c);
                    c = '0; c.regdst = 2'd1; c.rw = 1; push(4'd7, 1'($urandom), c);
                end
            end
            6'd4: begin
                c = '0; c.srca = 1; c.aluop = 3'd1; c.pcwc = 1; c.pcsrc = 2'd1;
                push(4'd8, 1'($urandom), c);
            end
            6'd8, 6'd13: begin
                c = '0; c.srca = 1; c.srcb = 2'd2; c.aluop = (op == 6'd13) ? 3'd3 : 3'd0;
                c.zext = (op == 6'd13); push(4'd9, 1'($urandom), c);
                c = '0; c.rw = 1; c.zext = (op == 6'd13); push(4'd10, 1'($urandom), c);
            end
            6'd2: begin
                c = '0; c.pcsrc = 2'd2; c.pcw = 1; push(4'd11, 1'($urandom), c);
            end
            6'd3: begin
                c = '0; c.regdst = 2'd2; c.m2r = 2'd2; c.rw = 1; c.pcsrc = 2'd2; c.pcw = 1;
                push(4'd12, 1'($urandom), c);
            end
            default: begin
                for (int i = 0; i < 21; i++) push(4'd14, 1'($urandom), '0);
            end
        endcase
        if (steps[steps.size()-1].st != 4'd14) steps[steps.size()-1].last = 1'b1;
    endtask

    // Entered and left just after a rising edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fs,
                             input int ms);
        ctrl_t got;
        int    mw_cnt;
        build(op, fn, fs, ms);
        opcode = op;
        funct  = fn;
        mw_cnt = 0;
        foreach (steps[i]) begin
            mem_ready = steps[i].rdy;
            zero      = 1'($urandom);
            exp_state = steps[i].st;
            exp_last  = steps[i].last;
            @(negedge clock);
            got = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                    RegWrite, ALUSrcA, ALUSrcB, ALUOp, ZeroExt, PCSource};
            check_eq($sformatf("state op%0d step%0d", op, i), 32'(state), 32'(steps[i].st));
            check_eq($sformatf("ctrl op%0d st%0d", op, steps[i].st), 32'(got), 32'(steps[i].c));
            check_eq($sformatf("illegal op%0d", op), 32'(illegal), 32'(steps[i].st == 4'd14));
`ifdef MCYCLE_PERF_EN
            check_eq("instr_count", instr_count, ins_exp);
            check_eq("cycle_count", cycle_count, cyc_exp);
`endif
            if (MemWrite) mw_cnt++;
            @(posedge clock);
            #1;
        end
        if (op == 6'd43) check_eq("sw_memwrite_cycles", 32'(mw_cnt), 32'd1);
    endtask

    task automatic check_in_reset(input string tag);
        ctrl_t got;
        ctrl_t exp_c;
        exp_c = '0;
        exp_c.srcb = 2'd1;
        @(negedge clock);
        got = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, ZeroExt, PCSource};
        check_eq({tag, " state"}, 32'(state), 32'd0);
        check_eq({tag, " ctrl"}, 32'(got), 32'(exp_c));
        check_eq({tag, " illegal"}, 32'(illegal), 32'd0);
`ifdef MCYCLE_PERF_EN
        check_eq({tag, " instr_count"}, instr_count, 32'd0);
        check_eq({tag, " cycle_count"}, cycle_count, 32'd0);
`endif
    endtask

    logic [5:0] ops[9];
    logic [5:0] fns[4];

    initial begin
        n_vec = 0; n_miss = 0;
        exp_state = 4'd0; exp_last = 1'b0;
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        ops = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd13, 6'd2, 6'd3};
        fns = '{6'd32, 6'd0, 6'd8, 6'd34};

        check_in_reset("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        run_instr(6'd0, 6'd32, 0, 0);   // add
        run_instr(6'd35, 6'd0, 0, 2);   // lw, memory stall
        run_instr(6'd43, 6'd0, 0, 3);   // sw, memory stall
        run_instr(6'd4, 6'd0, 2, 0);    // beq, fetch stall
        run_instr(6'd4, 6'd0, 0, 0);
        run_instr(6'd3, 6'd0, 0, 0);    // jal
        run_instr(6'd0, 6'd8, 0, 0);    // jr
        run_instr(6'd0, 6'd0, 0, 0);    // sll
        run_instr(6'd8, 6'd0, 0, 0);
        run_instr(6'd13, 6'd0, 1, 0);
        run_instr(6'd2, 6'd0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 3)];
            run_instr(op, fn, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 3));
        end

        // Abandon a lw in MEMRD by reset.
        opcode = 6'd35; funct = 6'd0; mem_ready = 1'b1; exp_state = 4'd0; exp_last = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        check_in_reset("mid_reset");
        @(posedge clock); #1;
        check_in_reset("mid_reset_hold");
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_instr(6'd43, 6'd0, 0, 1);

        run_instr(6'd63, 6'd0, 0, 0);   // illegal opcode, holds
        reset_n = 1'b0;
        exp_state = 4'd0;
        check_in_reset("illegal_reset");
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_instr(6'd0, 6'd32, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the MIPS datapath: one shared memory, one ALU, and IR/A/B/ALUOut holding registers.
- Decodes opcode/funct from the instruction register and drives per-state datapath controls.
- Stalls on a memory ready handshake.
- The ALUOp output feeds the existing ALU control unit (3-bit encoding: 0 add, 1 sub, 2 R-type, 3 or, 4 sll).

Parameters:
- OP_RTYPE, 6'd0, R-format opcode
- OP_LW, 6'd35, load word
- OP_SW, 6'd43, store word
- OP_BEQ, 6'd4, branch equal
- OP_ADDI, 6'd8, add immediate
- OP_ORI, 6'd13, or immediate
- OP_J, 6'd2, jump
- OP_JAL, 6'd3, jump and link

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- zero  in  1  ALU zero flag
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  2  write register select: 0=rt, 1=rd, 2=$31
- MemtoReg  out  2  write data select: 0=ALUOut, 1=MDR, 2=PC
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU B select: 0=B, 1=4, 2=ext imm, 3=ext imm<<2
- ALUOp  out  3  to ALU control unit
- ZeroExt  out  1  immediate zero-extend (ori) vs sign-extend
- PCSource  out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target, 3=A (jr)
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state (debug)

Behaviour:
- Clock port is clock; reset is asynchronous and active-low (reset_n).
- While reset_n=0: state=FETCH(0), illegal=0, and all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) forced 0.
- All other outputs take their FETCH values.
- Controls are a combinational decode of the registered state. Only mem_ready gates enables (Mealy); unlisted outputs are 0.

States (controls asserted -> next state):
- 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; IRWrite=PCWrite=mem_ready -> DECODE when mem_ready, else hold.
- 1 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R with funct=8 -> JR
  - other R -> EXEC
  - beq -> BRANCH
  - addi/ori -> IEXEC
  - j -> JUMP
  - jal -> JAL
  - anything else -> ILLEGAL
- 2 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> MEMRD (lw) / MEMWR (sw).
- 3 MEMRD: MemRead=1, IorD=1; hold until mem_ready -> MEMWB.
- 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- 5 MEMWR: IorD=1, MemWrite=mem_ready; hold until mem_ready -> FETCH.
- 6 EXEC: ALUSrcA=1, ALUSrcB=0; ALUOp=4 if funct=0 (sll), else 2 -> RWB.
- 7 RWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- 8 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1 -> FETCH.
- 9 IEXEC: ALUSrcA=1, ALUSrcB=2; ALUOp=0 (addi) or 3 (ori, with ZeroExt=1) -> IWB.
- 10 IWB: RegDst=0, MemtoReg=0, RegWrite=1; ZeroExt is held from IEXEC -> FETCH.
- 11 JUMP: PCSource=2, PCWrite=1 -> FETCH.
- 12 JAL: RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1 -> FETCH. Link value is the already-incremented PC.
- 13 JR: PCSource=3, PCWrite=1 -> FETCH.
- 14 ILLEGAL: illegal=1, no enables; stays here until reset.
- 15: unreachable; if entered, go to FETCH.

Cycle counts with mem_ready constantly 1:
- lw=5
- sw, R, addi/ori=4
- beq, j, jal, jr=3

Boundary conditions:
- mem_ready low in FETCH: PC and IR untouched, no double increment.
- Reset asserted mid-instruction: the instruction is abandoned immediately; no enable may glitch high after reset_n falls.
- MemWrite is asserted exactly one cycle per sw, the mem_ready cycle, regardless of stall length.

Optional Feature:
- Macro: MCYCLE_PERF_EN.
- When defined, adds two outputs:
  - instr_count (32 bits): increments on every transition into FETCH from a completing state.
  - cycle_count (32 bits): increments every cycle while not in ILLEGAL.
- Both counters reset to 0 on reset_n and wrap at 2^32-1 -> 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then mem_ready=1, opcode=0, funct=32: states 0,1,6,7,0; RegWrite=1 only in RWB with RegDst=1; instruction takes 4 cycles.
- lw (opcode 35) with mem_ready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0; MemtoReg=1 in MEMWB; IorD=1 in MEMRD.
- sw (opcode 43) with a 3-cycle stall: MemWrite high exactly 1 cycle; RegWrite never high.
- beq with zero=1, then with zero=0: PCWriteCond=1, PCSource=1 in BRANCH; ALUOp=1 both times.
- jal (opcode 3): RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1 in the same cycle; jr (funct 8) gives PCSource=3.
- Opcode 63: illegal=1, holds in state 14 for 20 cycles; reset_n pulse returns state to 0 and clears illegal. With MCYCLE_PERF_EN, counters read 0 after the pulse.
